// File: rtl/beat_pkg.sv
// beat_pkg: shared types, load-FSM encoding and the fine-period helper used by
// beat_clock for its reset-time period.
package beat_pkg;

  localparam int BEAT_W = 4;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_DIV  = 2'd1,
    LD_PEND = 2'd2
  } ld_state_t;

  // Cycles per finest subdivision; never returns less than 1.
  function automatic longint unsigned calc_fine_period(
    input longint unsigned clk_hz,
    input longint unsigned bpm,
    input int              num_div
  );
    longint unsigned v_div;
    longint unsigned v_p;
    v_div = bpm << (num_div - 1);
    if (v_div == 0) v_p = clk_hz * 60;
    else            v_p = (clk_hz * 60) / v_div;
    if (v_p < 1) v_p = 1;
    return v_p;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: CNT_W-bit restoring divider, one quotient bit per cycle.
// done_o pulses for one cycle once the quotient is final; a zero quotient reads as 1.
module seq_divider #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] quotient_o
);

  localparam int CW = $clog2(CNT_W + 1);

  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_quo;
  logic [CNT_W-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W:0]   w_shift;
  logic [CNT_W:0]   w_diff;

  // r_quo starts as the dividend and shifts quotient bits in from the right.
  assign w_shift = {r_rem, r_quo[CNT_W-1]};
  assign w_diff  = w_shift - {1'b0, r_div};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start_i && !r_busy) begin
        r_rem  <= '0;
        r_quo  <= dividend_i;
        r_div  <= divisor_i;
        r_cnt  <= CW'(CNT_W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (!w_diff[CNT_W]) begin
          r_rem <= w_diff[CNT_W-1:0];
          r_quo <= {r_quo[CNT_W-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[CNT_W-1:0];
          r_quo <= {r_quo[CNT_W-2:0], 1'b0};
        end
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign quotient_o = (r_quo == '0) ? CNT_W'(1) : r_quo;

endmodule

// File: rtl/beat_clock.sv
// beat_clock: runtime-BPM quarter/subdivision pulse generator with bar/beat count.
// Optional macro TAP_SYNC_EN adds sync_i, which clears the musical phase.
module beat_clock
  import beat_pkg::*;
#(
  parameter int CLK_HZ        = 6300000,
  parameter int NUM_DIV       = 3,
  parameter int BPM_W         = 9,
  parameter int BPM_MIN       = 30,
  parameter int BPM_MAX       = 300,
  parameter int DEFAULT_BPM   = 60,
  parameter int BEATS_PER_BAR = 4,
  parameter int CNT_W         = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               run_i,
  input  logic [BPM_W-1:0]   bpm_i,
  input  logic               bpm_valid_i,
`ifdef TAP_SYNC_EN
  input  logic               sync_i,
`endif
  output logic               bpm_ready_o,
  output logic [NUM_DIV-1:0] tick_o,
  output beat_t              beat_o,
  output logic               bar_o
);

  localparam int SUB_W = (NUM_DIV > 1) ? NUM_DIV - 1 : 1;
  localparam logic [CNT_W-1:0] DEFAULT_P =
    CNT_W'(calc_fine_period(64'(CLK_HZ), 64'(DEFAULT_BPM), NUM_DIV));
  localparam logic [CNT_W-1:0] DIVIDEND  = CNT_W'(64'(CLK_HZ) * 64'd60);
  localparam beat_t            LAST_BEAT = beat_t'(BEATS_PER_BAR - 1);

  logic [CNT_W-1:0]   r_fine;
  logic [CNT_W-1:0]   r_period;
  logic [CNT_W-1:0]   r_shadow;
  logic [SUB_W-1:0]   r_sub;
  beat_t              r_beat;
  logic [NUM_DIV-1:0] r_tick;
  logic               r_bar;
  ld_state_t          r_state;
  ld_state_t          w_state_next;

  logic               w_sync;
  logic               w_fine_wrap;
  logic               w_quarter;
  logic [NUM_DIV-1:0] w_tick;
  logic [CNT_W-1:0]   w_bpm_ext;
  logic [CNT_W-1:0]   w_bpm_clamped;
  logic [CNT_W-1:0]   w_divisor;
  logic [CNT_W-1:0]   w_quotient;
  logic               w_div_busy;
  logic               w_div_done;
  logic               w_ready;
  logic               w_accept;
  logic               w_commit_now;
  logic               w_commit_shadow;

`ifdef TAP_SYNC_EN
  assign w_sync = sync_i;
`else
  assign w_sync = 1'b0;
`endif

  // >= so a period shortened while paused cannot strand fine_cnt above the wrap point.
  assign w_fine_wrap = run_i && !w_sync && (r_fine >= r_period - 1'b1);

  for (genvar gi = 0; gi < NUM_DIV; gi++) begin : g_tick
    localparam logic [SUB_W-1:0] LOW_MASK = SUB_W'((1 << (NUM_DIV - 1 - gi)) - 1);
    assign w_tick[gi] = w_fine_wrap && ((r_sub & LOW_MASK) == LOW_MASK);
  end

  assign w_quarter = w_tick[0];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_fine <= '0;
      r_sub  <= '0;
      r_beat <= '0;
      r_tick <= '0;
      r_bar  <= 1'b0;
    end else begin
      r_tick <= w_tick;
      r_bar  <= w_quarter && (r_beat == LAST_BEAT);
      if (w_sync) begin
        r_fine <= '0;
        r_sub  <= '0;
        r_beat <= '0;
      end else if (w_fine_wrap) begin
        r_fine <= '0;
        r_sub  <= (NUM_DIV > 1) ? r_sub + 1'b1 : '0;
        if (w_quarter) r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
      end else if (run_i) begin
        r_fine <= r_fine + 1'b1;
      end
    end
  end

  assign w_bpm_ext = CNT_W'(bpm_i);

  always_comb begin
    w_bpm_clamped = w_bpm_ext;
    if (w_bpm_ext < CNT_W'(BPM_MIN))      w_bpm_clamped = CNT_W'(BPM_MIN);
    else if (w_bpm_ext > CNT_W'(BPM_MAX)) w_bpm_clamped = CNT_W'(BPM_MAX);
  end

  assign w_divisor = w_bpm_clamped << (NUM_DIV - 1);

  seq_divider #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (w_accept),
    .dividend_i (DIVIDEND),
    .divisor_i  (w_divisor),
    .busy_o     (w_div_busy),
    .done_o     (w_div_done),
    .quotient_o (w_quotient)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= LD_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LD_IDLE: if (w_accept) w_state_next = LD_DIV;
      LD_DIV:  if (w_div_done) w_state_next = (w_quarter || !run_i) ? LD_IDLE : LD_PEND;
      LD_PEND: if (w_quarter) w_state_next = LD_IDLE;
      default: w_state_next = LD_IDLE;
    endcase
  end

  always_comb begin
    w_ready         = 1'b0;
    w_accept        = 1'b0;
    w_commit_now    = 1'b0;
    w_commit_shadow = 1'b0;
    case (r_state)
      LD_IDLE: begin
        w_ready  = 1'b1;
        w_accept = bpm_valid_i && !w_div_busy;
      end
      LD_DIV:  w_commit_now    = w_div_done && (w_quarter || !run_i);
      LD_PEND: w_commit_shadow = w_quarter;
      default: ;
    endcase
  end

  // A commit on a quarter edge takes effect for the quarter that starts on that edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_period <= DEFAULT_P;
      r_shadow <= DEFAULT_P;
    end else begin
      if ((r_state == LD_DIV) && w_div_done) r_shadow <= w_quotient;
      if (w_commit_now)         r_period <= w_quotient;
      else if (w_commit_shadow) r_period <= r_shadow;
    end
  end

  assign bpm_ready_o = w_ready;
  assign tick_o      = r_tick;
  assign beat_o      = r_beat;
  assign bar_o       = r_bar;

endmodule

// File: tb/tb_beat_clock.sv
// tb_beat_clock: directed and randomized checks of beat_clock against a
// behavioural model built from fine periods, subdivision counts and a load queue.
module tb_beat_clock;
  import beat_pkg::*;

  localparam int CLK_HZ        = 64;
  localparam int NUM_DIV       = 3;
  localparam int BPM_W         = 9;
  localparam int BPM_MIN       = 30;
  localparam int BPM_MAX       = 300;
  localparam int DEFAULT_BPM   = 120;
  localparam int BEATS_PER_BAR = 4;
  localparam int CNT_W         = 32;
  localparam int SUBS          = 1 << (NUM_DIV - 1);
  // Edges from the accepting edge to the first edge that may commit the new period.
  localparam int DIV_LAT       = CNT_W + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               run = 1'b0;
  logic [BPM_W-1:0]   bpm = '0;
  logic               bpm_valid = 1'b0;
  logic               ready;
  logic [NUM_DIV-1:0] tick;
  beat_t              beat;
  logic               bar;
`ifdef TAP_SYNC_EN
  logic               sync = 1'b0;
`endif

  beat_clock #(
    .CLK_HZ(CLK_HZ), .NUM_DIV(NUM_DIV), .BPM_W(BPM_W), .BPM_MIN(BPM_MIN),
    .BPM_MAX(BPM_MAX), .DEFAULT_BPM(DEFAULT_BPM), .BEATS_PER_BAR(BEATS_PER_BAR),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .run_i       (run),
    .bpm_i       (bpm),
    .bpm_valid_i (bpm_valid),
`ifdef TAP_SYNC_EN
    .sync_i      (sync),
`endif
    .bpm_ready_o (ready),
    .tick_o      (tick),
    .beat_o      (beat),
    .bar_o       (bar)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model state: period, fine position, completed fine periods in the quarter, beat,
  // load phase (0 ready, 1 dividing, 2 waiting for quarter), and pending results.
  int m_p, m_fine, m_n, m_beat, m_ld, m_left, m_q, m_shadow;
  logic [NUM_DIV-1:0] m_tick;
  bit m_bar;
  int g_edge, last_q_edge, q_len, first_t2, first_t0, first_bar;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_period(input int b);
    int c;
    c = b;
    if (c < BPM_MIN) c = BPM_MIN;
    if (c > BPM_MAX) c = BPM_MAX;
    return int'(calc_fine_period(64'(CLK_HZ), 64'(c), NUM_DIV));
  endfunction

  task automatic model_reset();
    m_p = model_period(DEFAULT_BPM);
    m_fine = 0; m_n = 0; m_beat = 0; m_ld = 0; m_left = 0; m_q = 0; m_shadow = 0;
    m_tick = '0; m_bar = 1'b0;
    g_edge = 0; last_q_edge = 0; q_len = 0;
    first_t2 = -1; first_t0 = -1; first_bar = -1;
  endtask

  task automatic model_edge(input bit run_v, input bit valid_v, input int bpm_v, input bit sync_v);
    bit acc;
    bit quarter;
    int na;
    acc = valid_v && (m_ld == 0);
    quarter = 1'b0;
    m_tick = '0;
    m_bar = 1'b0;
    if (sync_v) begin
      m_fine = 0; m_n = 0; m_beat = 0;
    end else if (run_v) begin
      if (m_fine >= m_p - 1) begin
        m_fine = 0;
        na = m_n + 1;
        for (int k = 0; k < NUM_DIV; k++)
          if (na % (SUBS >> k) == 0) m_tick[k] = 1'b1;
        if (na == SUBS) begin
          quarter = 1'b1;
          m_n = 0;
          if (m_beat == BEATS_PER_BAR - 1) begin m_beat = 0; m_bar = 1'b1; end
          else m_beat++;
        end else begin
          m_n = na;
        end
      end else begin
        m_fine++;
      end
    end
    case (m_ld)
      0: if (acc) begin m_ld = 1; m_left = DIV_LAT; m_q = model_period(bpm_v); end
      1: begin
        m_left--;
        if (m_left == 0) begin
          if (quarter || !run_v) begin m_p = m_q; m_ld = 0; end
          else begin m_shadow = m_q; m_ld = 2; end
        end
      end
      2: if (quarter) begin m_p = m_shadow; m_ld = 0; end
      default: ;
    endcase
  endtask

  task automatic cycle(input bit run_v, input bit valid_v, input int bpm_v, input bit sync_v);
    run = run_v;
    bpm_valid = valid_v;
    bpm = BPM_W'(bpm_v);
`ifdef TAP_SYNC_EN
    sync = sync_v;
`endif
    @(posedge clk);
    model_edge(run_v, valid_v, bpm_v, sync_v);
    g_edge++;
    #1;
    check("tick",  32'(tick),  32'(m_tick));
    check("beat",  32'(beat),  32'(m_beat));
    check("bar",   32'(bar),   32'(m_bar));
    check("ready", 32'(ready), 32'(m_ld == 0));
    if (tick[NUM_DIV-1] && first_t2 < 0) first_t2 = g_edge;
    if (tick[0]) begin
      if (first_t0 < 0) first_t0 = g_edge;
      q_len = g_edge - last_q_edge;
      last_q_edge = g_edge;
    end
    if (bar && first_bar < 0) first_bar = g_edge;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int t2;
    int t0;
    bit found;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_tick",  32'(tick),  32'd0);
    check("rst_beat",  32'(beat),  32'd0);
    check("rst_bar",   32'(bar),   32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Default tempo from reset release
    for (int i = 0; i < 140; i++) cycle(1'b1, 1'b0, 0, 1'b0);
    check("first_tick2_edge", 32'(first_t2),  32'd8);
    check("first_tick0_edge", 32'(first_t0),  32'd32);
    check("first_bar_edge",   32'(first_bar), 32'd128);
    check("quarter_len_p8",   32'(q_len),     32'd32);

    // Load 60 BPM mid-quarter
    cycle(1'b1, 1'b1, 60, 1'b0);
    for (int i = 0; i < 200; i++) cycle(1'b1, 1'b0, 0, 1'b0);
    check("quarter_len_60bpm", 32'(q_len), 32'd64);

    // Load 0 -> clamps to 30 BPM
    cycle(1'b1, 1'b1, 0, 1'b0);
    for (int i = 0; i < 320; i++) cycle(1'b1, 1'b0, 0, 1'b0);
    check("quarter_len_min_clamp", 32'(q_len), 32'd128);

    // Load 400 -> clamps to 300 BPM
    cycle(1'b1, 1'b1, 400, 1'b0);
    for (int i = 0; i < 150; i++) cycle(1'b1, 1'b0, 0, 1'b0);
    check("quarter_len_max_clamp", 32'(q_len), 32'd12);

    // Asynchronous reset in the middle of a divide
    cycle(1'b1, 1'b1, 200, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 0, 1'b0);
    reset = 1'b1;
    #1;
    check("async_rst_tick",  32'(tick),  32'd0);
    check("async_rst_beat",  32'(beat),  32'd0);
    check("async_rst_bar",   32'(bar),   32'd0);
    check("async_rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Pause at fine_cnt=5 for 20 cycles
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      cycle(1'b1, 1'b0, 0, 1'b0);
      if (m_fine == 5) found = 1'b1;
    end
    check("reach_fine5", 32'(found), 32'd1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 0, 1'b0);
    cnt = 0;
    t2 = -1;
    for (int i = 0; i < 16 && t2 < 0; i++) begin
      cycle(1'b1, 1'b0, 0, 1'b0);
      cnt++;
      if (tick[NUM_DIV-1]) t2 = cnt;
    end
    check("resume_tick2_edges", 32'(t2), 32'd3);

`ifdef TAP_SYNC_EN
    // Tap sync at fine_cnt=6, beat=2
    found = 1'b0;
    for (int i = 0; i < 256 && !found; i++) begin
      cycle(1'b1, 1'b0, 0, 1'b0);
      if (m_fine == 6 && m_beat == 2) found = 1'b1;
    end
    check("reach_sync_point", 32'(found), 32'd1);
    cycle(1'b1, 1'b0, 0, 1'b1);
    check("sync_beat", 32'(beat), 32'd0);
    cnt = 0;
    t2 = -1;
    t0 = -1;
    for (int i = 0; i < 64 && t0 < 0; i++) begin
      cycle(1'b1, 1'b0, 0, 1'b0);
      cnt++;
      if (tick[NUM_DIV-1] && t2 < 0) t2 = cnt;
      if (tick[0]) t0 = cnt;
    end
    check("sync_tick2_edges", 32'(t2), 32'd8);
    check("sync_tick0_edges", 32'(t0), 32'd32);
`else
    t0 = 0;
`endif

    // Randomized run/pause, BPM requests and (when present) tap sync
    for (int i = 0; i < 1500; i++) begin
      bit r_run;
      bit r_val;
      bit r_syn;
      int r_bpm;
      r_run = ($urandom_range(0, 9) != 0);
      r_val = ($urandom_range(0, 15) == 0);
      r_bpm = int'($urandom_range(0, 511));
`ifdef TAP_SYNC_EN
      r_syn = ($urandom_range(0, 63) == 0);
`else
      r_syn = 1'b0;
`endif
      cycle(r_run, r_val, r_bpm, r_syn);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/beat_clock.md
Name: beat_clock

Overview:
Parametrised successor to the fixed-BPM note timer. Generates phase-aligned single-cycle pulses for the quarter note and each binary subdivision down to 1/(4·2^(NUM_DIV-1)) notes. Adds runtime-programmable BPM through a sequential divider, a run/pause control and a bar/beat counter. Sits between the song/chart sequencer (BPM source) and the note-spawn and scroll logic (pulse consumers).

Parameters:
CLK_HZ, 6300000, input clock frequency in Hz
NUM_DIV, 3, number of pulse outputs; k=0 quarter, k=1 eighth, k=2 sixteenth, …; range 1..6
BPM_W, 9, width of bpm_i
BPM_MIN, 30, clamp floor for loaded BPM
BPM_MAX, 300, clamp ceiling for loaded BPM
DEFAULT_BPM, 60, BPM in effect after reset
BEATS_PER_BAR, 4, quarters per bar; range 1..16
CNT_W, 32, width of period, counter and divider; must hold CLK_HZ*60

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous reset, active-high
run_i  in  1  1 = counters advance; 0 = hold all counters
bpm_i  in  BPM_W  requested BPM
bpm_valid_i  in  1  BPM request valid
bpm_ready_o  out  1  block can accept a BPM request
tick_o  out  NUM_DIV  one-cycle pulses; bit k fires every quarter/2^k
beat_o  out  4  quarter index within the bar, 0..BEATS_PER_BAR-1
bar_o  out  1  one-cycle pulse on the downbeat (beat_o wraps to 0)

Behaviour:
- Fine period: P = floor(CLK_HZ*60 / (bpm << (NUM_DIV-1))), clamped to a minimum of 1. Quarter length = P·2^(NUM_DIV-1) cycles.
- Reset (async): fine_cnt=0, sub_cnt=0, beat_o=0, tick_o=0, bar_o=0, bpm_ready_o=1, divider idle, active P = constant computed from DEFAULT_BPM.
- fine_cnt counts 0..P-1 on every edge with run_i=1. The edge where fine_cnt==P-1 is a fine wrap: fine_cnt←0 and sub_cnt (NUM_DIV-1 bits) increments modulo 2^(NUM_DIV-1).
- tick_o is registered and high for the single cycle after a fine wrap:
  - tick_o[NUM_DIV-1] fires on every wrap.
  - tick_o[k] fires when the pre-increment sub_cnt has its low (NUM_DIV-1-k) bits all ones.
  - tick_o[0] is the quarter pulse.
  - All coincident bits assert in the same cycle.
- On a quarter event, beat_o increments modulo BEATS_PER_BAR. bar_o pulses in the same cycle as tick_o[0] when beat_o wraps to 0.
- First pulse after reset release with run_i held high: tick_o[NUM_DIV-1] is high in the cycle after edge P. The first tick_o[0] follows edge P·2^(NUM_DIV-1).
- run_i=0: all counters freeze, no pulses. Resume continues from the frozen phase with no extra pulse.
- BPM load handshake:
  - Transfer occurs on an edge where bpm_valid_i && bpm_ready_o. bpm_ready_o drops the next cycle.
  - bpm_i is clamped to [BPM_MIN, BPM_MAX] (0 clamps to BPM_MIN).
  - The divisor (clamped << (NUM_DIV-1)) is fed to a restoring divider: one quotient bit per cycle, CNT_W cycles.
  - The result goes to a shadow register. bpm_ready_o returns to 1 after the shadow is committed.
- Commit point: the shadow becomes the active P on the next quarter event, so the current quarter completes with the old P. If run_i=0 when the divide finishes, commit is immediate. A second request cannot be accepted until commit.
- Simultaneous quarter event and divide completion: the new P applies from the following quarter; the current wrap uses the old P.
- Reset during a divide aborts it; the active P reverts to the DEFAULT_BPM value.

Optional Feature:
TAP_SYNC_EN.
- Defined: adds input sync_i (1 bit). A sync_i pulse on an edge clears fine_cnt, sub_cnt and beat_o and emits no pulse that cycle. Pending commits still wait for the next quarter event. sync_i has priority over a fine wrap in the same cycle.
- Undefined: the port is absent and phase is only cleared by reset.

Decomposition:
- Package beat_pkg:
  - constant BEAT_W=4
  - constant function calc_fine_period(clk_hz, bpm, num_div), used for the reset default and by the bench model
  - typedef beat_t = logic [BEAT_W-1:0]
- Sub-module seq_divider (CNT_W-bit restoring divider):
  - inputs start/dividend/divisor
  - outputs busy/done/quotient
  - a zero quotient is forced to 1

Test Plan:
- CLK_HZ=64, NUM_DIV=3, DEFAULT_BPM=120, run_i=1 from reset release → P=8: tick_o[2] every 8 cycles, tick_o[1] every 16, tick_o[0] every 32; bar_o every 128 cycles; first tick_o[2] one cycle after edge 8.
- Same config, load bpm_i=60 mid-quarter → bpm_ready_o low for the divide; current quarter still 32 cycles; the following quarter is 64 cycles (P=16); bpm_ready_o high after commit.
- Load bpm_i=0 → clamped to BPM_MIN=30 → P=32, quarter 128 cycles. Load bpm_i=400 → clamped to 300 → P=floor(3840/1200)=3.
- run_i low for 20 cycles at fine_cnt=5 → no pulses while low; after resume the next tick_o[2] arrives 3 run edges later; beat_o unchanged.
- Assert reset_i asynchronously mid-divide → outputs zero immediately, bpm_ready_o=1 on release, P=8 restored.
- With TAP_SYNC_EN defined, pulse sync_i at fine_cnt=6, beat_o=2 → beat_o=0; next tick_o[2] 8 cycles later; next tick_o[0] 32 cycles after sync.
